// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl
//   Sequencer for the 2x2 / stride-2 max-pool datapath. Latches the programmed
//   geometry on pool_start. Walks grp/col/row counters over the input stream.
//   Drives the partial-max buffer strobes and the emit strobe. Runs the output
//   valid/ready handshake and signals completion. Holds no pixel data.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   pool_start          one-cycle start request (honoured only in IDLE)
//   input_size          feature-map height = width in pixels
//   input_channel_size  channel count (4 int8 channels per beat)
//   s_valid / s_ready   input stream handshake
//   acc_we              buffer write strobe (one per accepted beat)
//   acc_addr            buffer entry = (col>>1)*ch_words + grp
//   acc_init            1: overwrite entry, 0: keep running max
//   emit                datapath captures the final max this cycle
//   m_valid / m_ready   output stream handshake, m_last marks final output
//   busy                job in progress (RUN or FLUSH)
//   pool_done           one-cycle completion pulse
//   cfg_err             set together with pool_done when the geometry was rejected
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for pool_start; geometry captured here
// RUN   | accepting input beats, emitting pooled outputs
// FLUSH | all input beats taken; waiting for the final output handshake
// DONE  | one cycle; pool_done (and cfg_err for rejected geometry)
module pool_seq_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              pool_start,
    input  logic [5:0]        input_size,
    input  logic [8:0]        input_channel_size,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              acc_we,
    output logic [ADDR_W-1:0] acc_addr,
    output logic              acc_init,
    output logic              emit,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              pool_done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] size_q;
    logic [6:0] ch_words_q;
    logic       err_q;
    logic [5:0] row_q, col_q;
    logic [6:0] grp_q;

    logic       geo_bad;
    logic       beat_ok;
    logic       grp_end, col_end, row_end, last_beat;
    logic       unused_ch_bits;

    // Low two channel bits are dropped: a partial beat of channels is not supported.
    assign unused_ch_bits = ^input_channel_size[1:0];

    assign geo_bad = (input_size == 6'd0) || input_size[0] || (input_size > 6'd32)
                     || (input_channel_size[8:2] == 7'd0);

    assign grp_end   = (grp_q == ch_words_q - 7'd1);
    assign col_end   = (col_q == size_q - 6'd1);
    assign row_end   = (row_q == size_q - 6'd1);
    assign last_beat = grp_end && col_end && row_end;

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        pool_done = 1'b0;
        cfg_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pool_start) begin
                    state_nxt = geo_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                // Back-pressure input only while an un-taken output is pending.
                s_ready = !m_valid || m_ready;
                if (s_valid && s_ready && last_beat) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (m_valid && m_ready && m_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                pool_done = 1'b1;
                cfg_err   = err_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign beat_ok  = s_valid && s_ready;
    assign acc_we   = beat_ok;
    assign acc_init = beat_ok && !row_q[0] && !col_q[0];
    assign emit     = beat_ok && row_q[0] && col_q[0];
    assign acc_addr = ADDR_W'(col_q[5:1]) * ADDR_W'(ch_words_q) + ADDR_W'(grp_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            size_q     <= '0;
            ch_words_q <= '0;
            err_q      <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            grp_q      <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_IDLE && pool_start) begin
                size_q     <= input_size;
                ch_words_q <= input_channel_size[8:2];
                err_q      <= geo_bad;
                row_q      <= '0;
                col_q      <= '0;
                grp_q      <= '0;
            end else if (beat_ok) begin
                if (grp_end) begin
                    grp_q <= '0;
                    if (col_end) begin
                        col_q <= '0;
                        row_q <= row_end ? 6'd0 : row_q + 6'd1;
                    end else begin
                        col_q <= col_q + 6'd1;
                    end
                end else begin
                    grp_q <= grp_q + 7'd1;
                end
            end

            // A new emit wins over the handshake so back-to-back outputs need no bubble.
            if (emit) begin
                m_valid <= 1'b1;
                m_last  <= last_beat;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
module tb_pool_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        pool_start = 1'b0;
    logic [5:0]  input_size = '0;
    logic [8:0]  input_channel_size = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        acc_we;
    logic [11:0] acc_addr;
    logic        acc_init;
    logic        emit;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        busy;
    logic        pool_done;
    logic        cfg_err;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];

    pool_seq_ctrl #(.ADDR_W(12)) dut (
        .CLK(CLK), .RESET(RESET), .pool_start(pool_start),
        .input_size(input_size), .input_channel_size(input_channel_size),
        .s_valid(s_valid), .s_ready(s_ready),
        .acc_we(acc_we), .acc_addr(acc_addr), .acc_init(acc_init), .emit(emit),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .pool_done(pool_done), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_acc_we"}, acc_we, 0);
        chk({tag, "_emit"}, emit, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pool_done"}, pool_done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Runs one job. Expected strobes come from the beat index alone.
    task automatic run_job(input int sz, input int ch, input int stall_len, input bit rnd,
                           input int repulse_at, input int abort_at,
                           output int n_beats, output int n_outs, output int last_beat_cyc,
                           output int last_hs_cyc, output int done_cyc);
        int  chw, total, b, stall_left, g, c, r;
        bit  first_emit, in_stall, fin, abort_now, pulsed;
        chw = ch / 4;
        total = sz * sz * chw;
        b = 0; n_outs = 0; last_beat_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        stall_left = 0; first_emit = 0; in_stall = 0; fin = 0; abort_now = 0; pulsed = 0;
        exp_q.delete();
        @(posedge CLK); #1;
        pool_start = 1'b1;
        input_size = 6'(sz);
        input_channel_size = 9'(ch);
        @(posedge CLK); #1;
        pool_start = 1'b0;
        s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            @(negedge CLK);
            if (in_stall) begin
                chk("stall_s_ready", s_ready, 0);
                chk("stall_m_valid", m_valid, 1);
            end
            if (m_valid && m_ready) begin
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("m_last", m_last, exp_q.pop_front());
                n_outs++;
                last_hs_cyc = cyc;
            end
            if (s_valid && s_ready) begin
                g = b % chw;
                c = (b / chw) % sz;
                r = b / (chw * sz);
                chk("acc_we", acc_we, 1);
                chk("acc_addr", acc_addr, (c / 2) * chw + g);
                chk("acc_init", acc_init, (r % 2 == 0) && (c % 2 == 0));
                chk("emit", emit, (r % 2 == 1) && (c % 2 == 1));
                if ((r % 2 == 1) && (c % 2 == 1)) exp_q.push_back(b == total - 1);
                if (b == total - 1) last_beat_cyc = cyc;
                b++;
                if (abort_at > 0 && b == abort_at) abort_now = 1;
            end else begin
                chk("idle_acc_we", acc_we, 0);
                chk("idle_emit", emit, 0);
            end
            if (emit && !first_emit && stall_len > 0) begin
                first_emit = 1;
                stall_left = stall_len;
            end
            if (pool_done) begin
                done_cyc = cyc;
                chk("done_cfg_err", cfg_err, 0);
                fin = 1;
            end
            if (!fin) begin
                @(posedge CLK); #1;
                if (abort_now) begin
                    RESET = 1'b1;
                    s_valid = 1'b1;
                    m_ready = 1'b1;
                    @(posedge CLK); #1;
                    RESET = 1'b0;
                    @(negedge CLK);
                    chk_all_zero("abort");
                    s_valid = 1'b0;
                    for (int k = 0; k < 6; k++) begin
                        @(negedge CLK);
                        chk("abort_no_done", pool_done, 0);
                        chk("abort_no_valid", m_valid, 0);
                    end
                    exp_q.delete();
                    n_beats = b;
                    return;
                end
                if (repulse_at > 0 && b == repulse_at && !pulsed) begin
                    pool_start = 1'b1;
                    input_size = 6'd2;
                    input_channel_size = 9'd8;
                    pulsed = 1;
                end else begin
                    pool_start = 1'b0;
                end
                in_stall = (stall_left > 0);
                if (in_stall) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else begin
                    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                s_valid = (b < total) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            end
        end
        n_beats = b;
        chk("done_seen", done_cyc >= 0, 1);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge CLK); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge CLK);
        chk("done_one_cycle", pool_done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic run_reject(input int sz, input int ch, input string tag);
        @(posedge CLK); #1;
        pool_start = 1'b1;
        input_size = 6'(sz);
        input_channel_size = 9'(ch);
        s_valid = 1'b1;
        @(posedge CLK); #1;
        pool_start = 1'b0;
        @(negedge CLK);
        chk({tag, "_pool_done"}, pool_done, 1);
        chk({tag, "_cfg_err"}, cfg_err, 1);
        chk({tag, "_s_ready"}, s_ready, 0);
        @(negedge CLK);
        chk({tag, "_done_clear"}, pool_done, 0);
        chk({tag, "_err_clear"}, cfg_err, 0);
        chk({tag, "_s_ready2"}, s_ready, 0);
        s_valid = 1'b0;
    endtask

    int nb, no, lb, lh, dc;

    initial begin
        RESET = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        @(posedge CLK); #1;
        RESET = 1'b0;
        s_valid = 1'b0;

        // size 4, 4 channels, no stalls
        run_job(4, 4, 0, 0, 0, 0, nb, no, lb, lh, dc);
        chk("j1_beats", nb, 16);
        chk("j1_outs", no, 4);
        chk("j1_done_lat", dc - lh, 1);

        // size 4, 8 channels, 5-cycle stall at first output
        run_job(4, 8, 5, 0, 0, 0, nb, no, lb, lh, dc);
        chk("j2_beats", nb, 32);
        chk("j2_outs", no, 8);
        chk("j2_done_lat", dc - lh, 1);

        // size 2, 4 channels
        run_job(2, 4, 0, 0, 0, 0, nb, no, lb, lh, dc);
        chk("j3_beats", nb, 4);
        chk("j3_outs", no, 1);
        chk("j3_done_after_last_beat", dc - lb, 2);

        // rejected geometry
        run_reject(3, 4, "rej_size3");
        run_reject(4, 2, "rej_ch2");
        run_reject(34, 4, "rej_size34");
        run_reject(0, 4, "rej_size0");

        // start re-pulsed mid-run with different geometry
        run_job(4, 4, 0, 0, 3, 0, nb, no, lb, lh, dc);
        chk("j4_beats", nb, 16);
        chk("j4_outs", no, 4);
        chk("j4_done_lat", dc - lh, 1);

        // reset after 6th beat, then a fresh job
        run_job(4, 4, 0, 0, 0, 6, nb, no, lb, lh, dc);
        chk("j5_abort_beats", nb, 6);
        run_job(4, 4, 0, 0, 0, 0, nb, no, lb, lh, dc);
        chk("j6_outs", no, 4);
        chk("j6_done_lat", dc - lh, 1);

        // random valid/ready traffic
        run_job(6, 12, 0, 1, 0, 0, nb, no, lb, lh, dc);
        chk("j7_beats", nb, 108);
        chk("j7_outs", no, 27);
        chk("j7_done_lat", dc - lh, 1);
        run_job(32, 4, 0, 1, 0, 0, nb, no, lb, lh, dc);
        chk("j8_beats", nb, 1024);
        chk("j8_outs", no, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
